// File: rtl/bpm_link_arbiter_if.sv
// Stream bundle for the BPM link arbiter: NREQ source streams in, one shared
// link stream out. The arbiter takes the master view; the environment
// (sources and link sink) takes the slave view.
interface bpm_link_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ*32-1:0] s_tdata;
  logic [NREQ-1:0]    s_tvalid;
  logic [NREQ-1:0]    s_tlast;
  logic [NREQ-1:0]    s_tready;

  logic [31:0]        BPM_TEST_AXI_STREAM_TX_tdata;
  logic               BPM_TEST_AXI_STREAM_TX_tvalid;
  logic               BPM_TEST_AXI_STREAM_TX_tlast;
  logic               BPM_TEST_AXI_STREAM_TX_tready;

  modport master (
    input  s_tdata,
    input  s_tvalid,
    input  s_tlast,
    output s_tready,
    output BPM_TEST_AXI_STREAM_TX_tdata,
    output BPM_TEST_AXI_STREAM_TX_tvalid,
    output BPM_TEST_AXI_STREAM_TX_tlast,
    input  BPM_TEST_AXI_STREAM_TX_tready
  );

  modport slave (
    output s_tdata,
    output s_tvalid,
    output s_tlast,
    input  s_tready,
    input  BPM_TEST_AXI_STREAM_TX_tdata,
    input  BPM_TEST_AXI_STREAM_TX_tvalid,
    input  BPM_TEST_AXI_STREAM_TX_tlast,
    output BPM_TEST_AXI_STREAM_TX_tready
  );
endinterface

// File: rtl/bpm_link_arbiter.sv
// Packet-granular round-robin arbiter sharing one stream link between NREQ
// sources. A grant is held for a whole packet; a packet stalled for TIMEOUT
// cycles is aborted and the rest of it is drained. An FA strobe makes the next
// arbitration restart from source 0. Internal signal/state names are
// snake_case; the externally visible ports keep the link's camelCase names.
module bpm_link_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                  auroraUserClk,
  input  logic                  auroraUserReset_n,
  input  logic                  auroraFAstrobe,
  input  logic [NREQ-1:0]       srcEnable,
  bpm_link_arbiter_if.master    bus,
  output logic [NREQ-1:0]       grant,
  output logic                  statusStrobe,
  output logic [1:0]            statusCode,
  output logic [15:0]           packetCount
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0]  LAST_IDX     = 2'(NREQ - 1);
  localparam logic [2:0]  NREQ_W       = 3'(NREQ);
  // The timeout fires on the edge that completes the TIMEOUT-th stalled cycle.
  localparam logic [15:0] STALL_LIMIT  = 16'(TIMEOUT - 1);
  localparam logic [1:0]  CODE_DONE    = 2'b01;
  localparam logic [1:0]  CODE_TIMEOUT = 2'b10;
  localparam logic [1:0]  CODE_DRAINED = 2'b11;

  // Reset: asserted asynchronously, released through two flops.
  logic rst_meta_r;
  logic rst_sync_r;

  state_t          state_r;
  logic [1:0]      gidx_r;
  logic [NREQ-1:0] grant_r;
  logic [1:0]      ptr_r;
  logic            fa_pend_r;
  logic [15:0]     stall_r;
  logic [15:0]     pkt_count_r;
  logic            strobe_r;
  logic [1:0]      code_r;

  // Sources padded to the maximum of four so indices are always 2 bits wide.
  logic [3:0]   valid_pad_s;
  logic [3:0]   last_pad_s;
  logic [3:0]   enable_pad_s;
  logic [127:0] data_pad_s;
  logic [3:0]   ready_pad_s;

  logic [1:0]   base_s;
  logic [2:0]   cand_ext_s;
  logic [1:0]   cand_s;
  logic         sel_found_s;
  logic [1:0]   sel_idx_s;
  logic [3:0]   grant_onehot_s;
  logic [1:0]   next_ptr_s;
  logic [1:0]   end_ptr_s;

  logic [31:0]  g_data_s;
  logic         g_valid_s;
  logic         g_last_s;
  logic [31:0]  link_data_s;
  logic         link_valid_s;
  logic         link_last_s;
  logic         beat_s;
  logic         drain_end_s;

  assign valid_pad_s  = 4'(bus.s_tvalid);
  assign last_pad_s   = 4'(bus.s_tlast);
  assign enable_pad_s = 4'(srcEnable);
  assign data_pad_s   = 128'(bus.s_tdata);

  // Two-flop release synchronizer; assertion stays immediate.
  always_ff @(posedge auroraUserClk or negedge auroraUserReset_n) begin
    if (!auroraUserReset_n) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  // Round-robin scan from ptr (or from 0 while an FA restart is pending).
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = 2'd0;
    cand_ext_s  = 3'd0;
    cand_s      = 2'd0;
    if (fa_pend_r) begin
      base_s = 2'd0;
    end else begin
      base_s = ptr_r;
    end
    for (int k = 0; k < NREQ; k++) begin
      cand_ext_s = {1'b0, base_s} + 3'(k);
      if (cand_ext_s >= NREQ_W) begin
        cand_ext_s = cand_ext_s - NREQ_W;
      end else begin
        cand_ext_s = cand_ext_s;
      end
      cand_s = cand_ext_s[1:0];
      if (!sel_found_s && valid_pad_s[cand_s] && enable_pad_s[cand_s]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  assign grant_onehot_s = 4'b0001 << sel_idx_s;
  assign next_ptr_s     = (gidx_r == LAST_IDX) ? 2'd0 : gidx_r + 2'd1;
  // A pending FA restart overrides the normal rotation on the same edge.
  assign end_ptr_s      = fa_pend_r ? 2'd0 : next_ptr_s;

  // Link mux and per-source ready, combinational from the granted source.
  always_comb begin
    g_data_s     = data_pad_s[{gidx_r, 5'd0} +: 32];
    g_valid_s    = valid_pad_s[gidx_r];
    g_last_s     = last_pad_s[gidx_r];
    ready_pad_s  = 4'd0;
    link_data_s  = 32'd0;
    link_valid_s = 1'b0;
    link_last_s  = 1'b0;
    case (state_r)
      ST_PASS: begin
        link_data_s         = g_data_s;
        link_valid_s        = g_valid_s;
        link_last_s         = g_last_s;
        ready_pad_s[gidx_r] = bus.BPM_TEST_AXI_STREAM_TX_tready;
      end
      ST_DRAIN: begin
        ready_pad_s[gidx_r] = 1'b1;
      end
      default: begin
        ready_pad_s = 4'd0;
      end
    endcase
  end

  assign beat_s      = link_valid_s & bus.BPM_TEST_AXI_STREAM_TX_tready;
  assign drain_end_s = (state_r == ST_DRAIN) & g_valid_s & g_last_s;

  // Arbitration FSM with its registered grant, status and counters.
  always_ff @(posedge auroraUserClk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      state_r     <= ST_ARB;
      gidx_r      <= 2'd0;
      grant_r     <= '0;
      ptr_r       <= 2'd0;
      fa_pend_r   <= 1'b0;
      stall_r     <= 16'd0;
      pkt_count_r <= 16'd0;
      strobe_r    <= 1'b0;
      code_r      <= 2'b00;
    end else begin
      strobe_r <= 1'b0;
      case (state_r)
        ST_ARB: begin
          if (sel_found_s) begin
            state_r <= ST_PASS;
            gidx_r  <= sel_idx_s;
            grant_r <= grant_onehot_s[NREQ-1:0];
            stall_r <= 16'd0;
            if (fa_pend_r) begin
              ptr_r     <= 2'd0;
              fa_pend_r <= 1'b0;
            end
          end
        end
        ST_PASS: begin
          if (beat_s) begin
            stall_r <= 16'd0;
            if (link_last_s) begin
              state_r     <= ST_ARB;
              grant_r     <= '0;
              ptr_r       <= end_ptr_s;
              fa_pend_r   <= 1'b0;
              pkt_count_r <= pkt_count_r + 16'd1;
              strobe_r    <= 1'b1;
              code_r      <= CODE_DONE;
            end
          end else if (stall_r == STALL_LIMIT) begin
            state_r  <= ST_DRAIN;
            stall_r  <= stall_r + 16'd1;
            strobe_r <= 1'b1;
            code_r   <= CODE_TIMEOUT;
          end else begin
            stall_r <= stall_r + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_end_s) begin
            state_r   <= ST_ARB;
            grant_r   <= '0;
            ptr_r     <= end_ptr_s;
            fa_pend_r <= 1'b0;
            strobe_r  <= 1'b1;
            code_r    <= CODE_DRAINED;
          end
        end
        default: begin
          state_r <= ST_ARB;
          grant_r <= '0;
        end
      endcase
      // A new FA strobe wins over a same-edge consumption of the old one.
      if (auroraFAstrobe) begin
        fa_pend_r <= 1'b1;
      end
    end
  end

  assign bus.s_tready                      = ready_pad_s[NREQ-1:0];
  assign bus.BPM_TEST_AXI_STREAM_TX_tdata  = link_data_s;
  assign bus.BPM_TEST_AXI_STREAM_TX_tvalid = link_valid_s;
  assign bus.BPM_TEST_AXI_STREAM_TX_tlast  = link_last_s;

  assign grant        = grant_r;
  assign statusStrobe = strobe_r;
  assign statusCode   = code_r;
  assign packetCount  = pkt_count_r;

endmodule

// File: tb/tb_bpm_link_arbiter.sv
// Scoreboard bench for bpm_link_arbiter: the stimulus side pushes expected
// link beats and status codes; negedge monitors pop and compare.
module tb_bpm_link_arbiter;
  localparam int NREQ = 2;
  localparam int TMO  = 8;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          src;
    int          gap;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic             fa;
  logic [NREQ-1:0]  en;
  logic             link_rdy;
  logic             tv [2];
  logic             tl [2];
  logic [31:0]      td [2];
  logic [NREQ-1:0]  grant;
  logic             strobe;
  logic [1:0]       code;
  logic [15:0]      pcount;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_end_cyc = 0;
  bit          chk_mirror = 1'b0;
  logic [15:0] exp_count;
  beat_t       exp_q[$];
  logic [1:0]  ev_q[$];
  beat_t       mon_b;
  logic [1:0]  mon_code;

  bpm_link_arbiter_if #(.NREQ(NREQ)) bus ();

  assign bus.s_tvalid = {tv[1], tv[0]};
  assign bus.s_tlast  = {tl[1], tl[0]};
  assign bus.s_tdata  = {td[1], td[0]};
  assign bus.BPM_TEST_AXI_STREAM_TX_tready = link_rdy;

  bpm_link_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .auroraUserClk     (clk),
    .auroraUserReset_n (rst_n),
    .auroraFAstrobe    (fa),
    .srcEnable         (en),
    .bus               (bus),
    .grant             (grant),
    .statusStrobe      (strobe),
    .statusCode        (code),
    .packetCount       (pcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input int src, input logic [31:0] base, input int n, input int gap);
    for (int b = 0; b < n; b++) begin
      exp_q.push_back('{base + 32'(b), (b == n - 1), src, (b == 0) ? gap : 0});
    end
    ev_q.push_back(2'b01);
    exp_count = exp_count + 16'd1;
  endtask

  // Drive n beats on source src, each held until the arbiter takes it.
  task automatic send_pkt(input int src, input logic [31:0] base, input int n, input bit last_end);
    int cnt;
    for (int b = 0; b < n; b++) begin
      tv[src] = 1'b1;
      td[src] = base + 32'(b);
      tl[src] = last_end && (b == n - 1);
      cnt = 0;
      @(negedge clk);
      while (!bus.s_tready[src]) begin
        if (cnt > 300) begin
          n_tests++;
          n_fail++;
          $display("FAIL send_timeout: src %0d beat %0d never accepted", src, b);
          tv[src] = 1'b0;
          tl[src] = 1'b0;
          return;
        end
        @(negedge clk);
        cnt++;
      end
      @(posedge clk);
      #1;
    end
    tv[src] = 1'b0;
    tl[src] = 1'b0;
  endtask

  // Link, status and ready-mirror monitors.
  always @(negedge clk) begin
    if (rst_n && bus.BPM_TEST_AXI_STREAM_TX_tvalid && link_rdy) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL link_unexpected_beat: got data %0h, expected no beat",
                 bus.BPM_TEST_AXI_STREAM_TX_tdata);
      end else begin
        mon_b = exp_q.pop_front();
        check("link_data", bus.BPM_TEST_AXI_STREAM_TX_tdata, mon_b.data);
        check("link_last", 32'(bus.BPM_TEST_AXI_STREAM_TX_tlast), 32'(mon_b.last));
        check("link_grant", 32'(grant), 32'(1) << mon_b.src);
        if (mon_b.gap > 0) begin
          check("arb_latency", 32'(cyc - last_end_cyc), 32'(mon_b.gap));
        end
      end
      if (bus.BPM_TEST_AXI_STREAM_TX_tlast) last_end_cyc = cyc;
    end
    if (rst_n && strobe) begin
      if (ev_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL status_unexpected: got code %0d, expected no event", code);
      end else begin
        mon_code = ev_q.pop_front();
        check("status_code", 32'(code), 32'(mon_code));
      end
    end
    if (chk_mirror && grant[0]) begin
      check("s_tready_mirror", 32'(bus.s_tready[0]), 32'(link_rdy));
    end
  end

  task automatic check_idle(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_count"}, 32'(pcount), 32'(exp_count));
    check({tag, "_link_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_events_left"}, 32'(ev_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; fa = 1'b0; en = 2'b11; link_rdy = 1'b1;
    tv[0] = 1'b0; tv[1] = 1'b0; tl[0] = 1'b0; tl[1] = 1'b0;
    td[0] = 32'd0; td[1] = 32'd0;
    exp_count = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_link_tvalid", 32'(bus.BPM_TEST_AXI_STREAM_TX_tvalid), 32'd0);
    check("reset_s_tready", 32'(bus.s_tready), 32'd0);
    check("reset_strobe", 32'(strobe), 32'd0);
    check("reset_code", 32'(code), 32'd0);
    check("reset_count", 32'(pcount), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Two sources, two 3-beat packets each: strict alternation.
    push_pkt(0, 32'h1000_0000, 3, 0);
    push_pkt(1, 32'h2000_0000, 3, 2);
    push_pkt(0, 32'h1000_0010, 3, 2);
    push_pkt(1, 32'h2000_0010, 3, 2);
    fork
      begin send_pkt(0, 32'h1000_0000, 3, 1'b1); send_pkt(0, 32'h1000_0010, 3, 1'b1); end
      begin send_pkt(1, 32'h2000_0000, 3, 1'b1); send_pkt(1, 32'h2000_0010, 3, 1'b1); end
    join
    check_idle("alternate");

    // Grant held through a competing request and an enable drop.
    push_pkt(0, 32'h3000_0000, 4, 0);
    push_pkt(1, 32'h4000_0000, 2, 2);
    fork
      send_pkt(0, 32'h3000_0000, 4, 1'b1);
      begin repeat (2) @(posedge clk); #1; send_pkt(1, 32'h4000_0000, 2, 1'b1); end
      begin repeat (3) @(posedge clk); #1; en[0] = 1'b0; end
    join
    en[0] = 1'b1;
    check_idle("hold");

    // Stall timeout on source 1, then the tail of its packet is drained.
    exp_q.push_back('{32'h5000_0000, 1'b0, 1, 0});
    ev_q.push_back(2'b10);
    ev_q.push_back(2'b11);
    send_pkt(1, 32'h5000_0000, 1, 1'b0);
    repeat (TMO) @(posedge clk);
    #1;
    check("drain_grant_held", 32'(grant), 32'h2);
    check("drain_link_tvalid", 32'(bus.BPM_TEST_AXI_STREAM_TX_tvalid), 32'd0);
    send_pkt(1, 32'h5000_0001, 2, 1'b1);
    check_idle("timeout");

    // FA strobe during packets: packets intact, next grant restarts at src0.
    push_pkt(1, 32'h6000_0000, 4, 0);
    push_pkt(0, 32'h7000_0000, 3, 2);
    push_pkt(0, 32'h7000_0010, 2, 2);
    push_pkt(1, 32'h6000_0010, 2, 2);
    fork
      begin send_pkt(1, 32'h6000_0000, 4, 1'b1); send_pkt(1, 32'h6000_0010, 2, 1'b1); end
      begin
        repeat (2) @(posedge clk); #1;
        send_pkt(0, 32'h7000_0000, 3, 1'b1);
        send_pkt(0, 32'h7000_0010, 2, 1'b1);
      end
      begin
        repeat (2) @(posedge clk); #1; fa = 1'b1;
        @(posedge clk); #1; fa = 1'b0;
        repeat (4) @(posedge clk); #1; fa = 1'b1;
        @(posedge clk); #1; fa = 1'b0;
      end
    join
    check_idle("fa_restart");

    // Link backpressure toggling every cycle during a 5-beat packet.
    push_pkt(0, 32'h8000_0000, 5, 0);
    chk_mirror = 1'b1;
    fork
      send_pkt(0, 32'h8000_0000, 5, 1'b1);
      for (int i = 0; i < 16; i++) begin
        @(posedge clk); #1;
        link_rdy = ~link_rdy;
      end
    join
    link_rdy = 1'b1;
    chk_mirror = 1'b0;
    check_idle("backpressure");

    // packetCount wrap from 0xFFFF, also a single-beat packet.
    @(negedge clk);
    force dut.pkt_count_r = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_count_r;
    exp_count = 16'hFFFF;
    @(posedge clk);
    #1;
    check("preload_count", 32'(pcount), 32'h0000_FFFF);
    push_pkt(0, 32'h9000_0000, 1, 0);
    send_pkt(0, 32'h9000_0000, 1, 1'b1);
    check("single_beat_grant_clear", 32'(grant), 32'd0);
    check_idle("wrap");

    // Reset in the middle of a source-1 packet.
    exp_q.push_back('{32'hA000_0000, 1'b0, 1, 0});
    exp_q.push_back('{32'hA000_0001, 1'b0, 1, 0});
    tv[1] = 1'b1; td[1] = 32'hA000_0000; tl[1] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1; td[1] = 32'hA000_0001;
    @(posedge clk); #1; td[1] = 32'hA000_0002;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_link_tvalid", 32'(bus.BPM_TEST_AXI_STREAM_TX_tvalid), 32'd0);
    check("midrst_s_tready", 32'(bus.s_tready), 32'd0);
    check("midrst_strobe", 32'(strobe), 32'd0);
    check("midrst_code", 32'(code), 32'd0);
    check("midrst_count", 32'(pcount), 32'd0);
    tv[1] = 1'b0;
    exp_count = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push_pkt(0, 32'hB000_0000, 1, 0);
    push_pkt(1, 32'hB100_0000, 1, 2);
    fork
      send_pkt(0, 32'hB000_0000, 1, 1'b1);
      send_pkt(1, 32'hB100_0000, 1, 1'b1);
    join
    check_idle("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
